hazard_forwarding_unit: RTL and testbench
=========================================

Name: hazard_forwarding_unit

Overview:
- Sits in the ID stage of the 5-stage RISC-V pipeline, directly upstream of the control-unit NOP mux and the ID operand four-to-one muxes.
- Keeps a shadow pipeline of destination-register info for EX/MEM/WB.
- Detects load-use hazards and drives the NOP-insert selector and the PC and IF/ID load enables.
- Drives the forwarding selects for the rs1 and rs2 operand muxes, and handles branch/jump flushes.

Parameters:
REG_ADDR_W, 5, register-index width
STAT_W, 32, width of optional statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ID_rs1  input  REG_ADDR_W  rs1 index of instruction in ID
ID_rs2  input  REG_ADDR_W  rs2 index of instruction in ID
ID_uses_rs1  input  1  instruction in ID reads rs1
ID_uses_rs2  input  1  instruction in ID reads rs2
ID_rd  input  REG_ADDR_W  rd index of instruction in ID
ID_RF_Enable  input  1  instruction in ID writes the register file (pre-mux value)
ID_Load_Instr  input  1  instruction in ID is a load (pre-mux value)
EX_flush  input  1  taken branch/JAL/JALR resolved this cycle
cu_mux_sel  output  1  1 = control-unit mux inserts NOP
PC_LE  output  1  PC load enable
IF_ID_LE  output  1  IF/ID register load enable
IF_ID_CLR  output  1  clear IF/ID to NOP on the next edge
fwd_sel_a  output  2  rs1 operand mux select: 00 RF, 01 EX, 10 MEM, 11 WB
fwd_sel_b  output  2  rs2 operand mux select, same encoding
stall_count  output  STAT_W  load-use stall cycles (only with feature)
fwd_count  output  STAT_W  forwarded-operand events (only with feature)

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Shadow state per stage S in {EX, MEM, WB}: S_rd, S_we, S_load.
  - Cleared to 0 on a reset edge.
- Shadow update on each non-reset edge:
  - EX takes {ID_rd, ID_RF_Enable, ID_Load_Instr} unless a bubble is inserted (cu_mux_sel=1); a bubble loads all zeros.
  - MEM takes EX; WB takes MEM.
- Match definition: match_S(r) = S_we && (S_rd == r) && (r != 0). x0 never forwards and never stalls.
- Load-use stall: stall = EX_load && ((ID_uses_rs1 && match_EX(ID_rs1)) || (ID_uses_rs2 && match_EX(ID_rs2))).
  - Stall lasts exactly one cycle, because the load moves to MEM on the next edge.
  - A MEM-stage load forwards its data and does not stall.
- Forwarding priority: EX > MEM > WB > RF.
  - Select 01 if match_EX and !EX_load; else 10 if match_MEM; else 11 if match_WB; else 00.
  - Operand not used -> 00.
- Output equations (combinational on shadow state and ID inputs; zero-cycle latency):
  - normal: cu_mux_sel=0, PC_LE=1, IF_ID_LE=1, IF_ID_CLR=0
  - stall: cu_mux_sel=1, PC_LE=0, IF_ID_LE=0, IF_ID_CLR=0
  - EX_flush: cu_mux_sel=1, PC_LE=1, IF_ID_LE=1, IF_ID_CLR=1
- Flush and stall together: flush wins; the stalled instruction is on the wrong path.
- While reset=1: cu_mux_sel=1, PC_LE=0, IF_ID_LE=0, IF_ID_CLR=0, fwd_sel_a/b=00.
- First cycle after reset release: all shadows are 0, so outputs are normal with fwd=00.
- Reset mid-stall: the stall is dropped and the shadows are emptied.
- fwd_sel values are still driven during stall/flush, but downstream ignores them.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_count increments by 1 each cycle where stall && !EX_flush && !reset.
  - fwd_count increments by the number of non-00 fwd selects (0, 1 or 2) on cycles with no stall, flush or reset.
  - Both counters wrap modulo 2^STAT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/header holds:
  - forwarding encodings FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11
  - REG_ADDR_W default
  - shadow-entry field widths
- One sub-module, hazard_shadow_stage: a single registered {rd, we, load} entry with synchronous clear and bubble load. It is instantiated three times.

Test Plan:
- Load-use: `lw x5` enters EX, then `add x6,x5,x7` in ID (uses_rs1=1) -> one cycle with cu_mux_sel=1, PC_LE=0, IF_ID_LE=0. Next cycle fwd_sel_a=10, no stall.
- Back-to-back ALU ops: `add x3` in EX, `sub x4,x3,x3` in ID -> fwd_sel_a=01, fwd_sel_b=01, cu_mux_sel=0.
- Priority: x9 written by the instructions in EX, MEM and WB, ID reads x9 -> 01. Kill the EX writer (RF_Enable=0) -> 10. Kill the MEM writer too -> 11.
- x0: EX writer has rd=0 with we=1, ID reads x0 -> fwd 00 and no stall, even if it is a load.
- Flush with stall: `lw x5` in EX, dependent op in ID, EX_flush=1 -> cu_mux_sel=1, PC_LE=1, IF_ID_LE=1, IF_ID_CLR=1. With the feature on, stall_count stays unchanged.
- Reset: assert reset during a stall for 1 cycle -> outputs take the reset values. On release all fwd are 00; with HAZARD_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_forwarding_unit_pkg.sv
// Shared definitions for the ID-stage hazard/forwarding unit: operand-mux
// encodings, default widths and shadow-entry field widths.
package hazard_forwarding_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int STAT_W_DEF     = 32;

  // Field widths of one {rd, we, load} shadow entry (rd width is REG_ADDR_W)
  localparam int SHADOW_WE_W   = 1;
  localparam int SHADOW_LOAD_W = 1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  // Number of operands (0..2) actually taking a bypass path this cycle
  function automatic logic [1:0] fwd_events(input logic [1:0] sel_a,
                                            input logic [1:0] sel_b);
    logic [1:0] n;
    n = {1'b0, sel_a != FWD_RF} + {1'b0, sel_b != FWD_RF};
    return n;
  endfunction

endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// ID-stage hazard bundle: decoded register usage in, stall/flush/forward
// controls out. Statistics members are only driven with HAZARD_STATS_EN.
interface hazard_forwarding_unit_if
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int STAT_W     = STAT_W_DEF
);

  logic [REG_ADDR_W-1:0] ID_rs1;
  logic [REG_ADDR_W-1:0] ID_rs2;
  logic                  ID_uses_rs1;
  logic                  ID_uses_rs2;
  logic [REG_ADDR_W-1:0] ID_rd;
  logic                  ID_RF_Enable;
  logic                  ID_Load_Instr;
  logic                  EX_flush;

  logic                  cu_mux_sel;
  logic                  PC_LE;
  logic                  IF_ID_LE;
  logic                  IF_ID_CLR;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic [STAT_W-1:0]     stall_count;
  logic [STAT_W-1:0]     fwd_count;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_rd,
           ID_RF_Enable, ID_Load_Instr, EX_flush,
    input  cu_mux_sel, PC_LE, IF_ID_LE, IF_ID_CLR,
           fwd_sel_a, fwd_sel_b, stall_count, fwd_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_rd,
           ID_RF_Enable, ID_Load_Instr, EX_flush,
    output cu_mux_sel, PC_LE, IF_ID_LE, IF_ID_CLR,
           fwd_sel_a, fwd_sel_b, stall_count, fwd_count
  );

endinterface

// File: rtl/hazard_forwarding_unit_shadow_stage.sv
// One shadow pipeline entry {rd, we, load}; reset and bubble both load an
// empty entry so a NOP never matches any consumer.
module hazard_shadow_stage
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bubble,
  input  logic [REG_ADDR_W-1:0]    nxt_rd,
  input  logic [SHADOW_WE_W-1:0]   nxt_we,
  input  logic [SHADOW_LOAD_W-1:0] nxt_load,
  output logic [REG_ADDR_W-1:0]    rd,
  output logic [SHADOW_WE_W-1:0]   we,
  output logic [SHADOW_LOAD_W-1:0] load
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      rd   <= '0;
      we   <= '0;
      load <= '0;
    end else begin
      rd   <= nxt_rd;
      we   <= nxt_we;
      load <= nxt_load;
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// ID-stage load-use stall, branch flush and operand-forwarding control.
// Optional HAZARD_STATS_EN adds stall/forward event counters.
module hazard_forwarding_unit
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int STAT_W     = STAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  hazard_forwarding_unit_if.slave  bus
);

  logic [REG_ADDR_W-1:0] ex_rd,   mem_rd,   wb_rd;
  logic                  ex_we,   mem_we,   wb_we;
  logic                  ex_load, mem_load, wb_load;

  logic m_ex_a, m_mem_a, m_wb_a;
  logic m_ex_b, m_mem_b, m_wb_b;
  logic stall;
  logic [1:0] fwd_a, fwd_b;

  function automatic logic reg_match(input logic                  s_we,
                                     input logic [REG_ADDR_W-1:0] s_rd,
                                     input logic [REG_ADDR_W-1:0] r);
    return s_we && (s_rd == r) && (r != '0);
  endfunction

  // A load in EX has no data yet, so it is skipped and the next-older match wins
  function automatic logic [1:0] fwd_pick(input logic used,
                                          input logic hit_ex,
                                          input logic ex_is_load,
                                          input logic hit_mem,
                                          input logic hit_wb);
    if (!used)                   return FWD_RF;
    else if (hit_ex && !ex_is_load) return FWD_EX;
    else if (hit_mem)            return FWD_MEM;
    else if (hit_wb)             return FWD_WB;
    else                         return FWD_RF;
  endfunction

  // ---- shadow pipeline: ID -> EX -> MEM -> WB ----
  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk      (clk),
    .reset    (reset),
    .bubble   (bus.cu_mux_sel),
    .nxt_rd   (bus.ID_rd),
    .nxt_we   (bus.ID_RF_Enable),
    .nxt_load (bus.ID_Load_Instr),
    .rd       (ex_rd),
    .we       (ex_we),
    .load     (ex_load)
  );

  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .nxt_rd   (ex_rd),
    .nxt_we   (ex_we),
    .nxt_load (ex_load),
    .rd       (mem_rd),
    .we       (mem_we),
    .load     (mem_load)
  );

  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .nxt_rd   (mem_rd),
    .nxt_we   (mem_we),
    .nxt_load (mem_load),
    .rd       (wb_rd),
    .we       (wb_we),
    .load     (wb_load)
  );

  // ---- ID-stage hazard detection and operand selection ----
  always_comb begin
    m_ex_a  = reg_match(ex_we,  ex_rd,  bus.ID_rs1);
    m_mem_a = reg_match(mem_we, mem_rd, bus.ID_rs1);
    m_wb_a  = reg_match(wb_we,  wb_rd,  bus.ID_rs1);
    m_ex_b  = reg_match(ex_we,  ex_rd,  bus.ID_rs2);
    m_mem_b = reg_match(mem_we, mem_rd, bus.ID_rs2);
    m_wb_b  = reg_match(wb_we,  wb_rd,  bus.ID_rs2);

    stall = ex_load && ((bus.ID_uses_rs1 && m_ex_a) ||
                        (bus.ID_uses_rs2 && m_ex_b));

    fwd_a = fwd_pick(bus.ID_uses_rs1, m_ex_a, ex_load, m_mem_a, m_wb_a);
    fwd_b = fwd_pick(bus.ID_uses_rs2, m_ex_b, ex_load, m_mem_b, m_wb_b);
  end

  // Reset beats flush, flush beats stall: a stalled op behind a taken branch is dead
  always_comb begin
    bus.cu_mux_sel = 1'b0;
    bus.PC_LE      = 1'b1;
    bus.IF_ID_LE   = 1'b1;
    bus.IF_ID_CLR  = 1'b0;
    bus.fwd_sel_a  = fwd_a;
    bus.fwd_sel_b  = fwd_b;
    if (reset) begin
      bus.cu_mux_sel = 1'b1;
      bus.PC_LE      = 1'b0;
      bus.IF_ID_LE   = 1'b0;
      bus.fwd_sel_a  = FWD_RF;
      bus.fwd_sel_b  = FWD_RF;
    end else if (bus.EX_flush) begin
      bus.cu_mux_sel = 1'b1;
      bus.IF_ID_CLR  = 1'b1;
    end else if (stall) begin
      bus.cu_mux_sel = 1'b1;
      bus.PC_LE      = 1'b0;
      bus.IF_ID_LE   = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt, fwd_cnt;

  // ---- statistics counters (wrap naturally) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && !bus.EX_flush)
        stall_cnt <= stall_cnt + STAT_W'(1);
      if (!stall && !bus.EX_flush)
        fwd_cnt <= fwd_cnt + STAT_W'(fwd_events(fwd_a, fwd_b));
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.fwd_count   = fwd_cnt;
`else
  assign bus.stall_count = {STAT_W{1'b0}};
  assign bus.fwd_count   = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Scenario bench for hazard_forwarding_unit; counter expectations follow
// HAZARD_STATS_EN when it is defined for the build.
module tb_hazard_forwarding_unit;

  localparam int RW = 5;
  localparam int SW = 32;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [3:0] C_NORM  = 4'b0110;  // {cu_mux_sel, PC_LE, IF_ID_LE, IF_ID_CLR}
  localparam logic [3:0] C_STALL = 4'b1000;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RST   = 4'b1000;

  typedef struct {
    logic          rst;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic          fl;
    logic [7:0]    exp;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  row_t sb[$];

  hazard_forwarding_unit_if #(.REG_ADDR_W(RW), .STAT_W(SW)) bus ();

  hazard_forwarding_unit #(.REG_ADDR_W(RW), .STAT_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic row_t mk(input logic rst, input logic [RW-1:0] rd,
                              input logic we, input logic ld,
                              input logic [RW-1:0] rs1, input logic u1,
                              input logic [RW-1:0] rs2, input logic u2,
                              input logic fl, input logic [3:0] ctl,
                              input logic [1:0] fa, input logic [1:0] fb);
    row_t r;
    r.rst = rst; r.rd = rd; r.we = we; r.ld = ld;
    r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.fl = fl;
    r.exp = {ctl, fa, fb};
    return r;
  endfunction

  function automatic logic [7:0] outs();
    return {bus.cu_mux_sel, bus.PC_LE, bus.IF_ID_LE, bus.IF_ID_CLR,
            bus.fwd_sel_a, bus.fwd_sel_b};
  endfunction

  task automatic drive(input row_t r);
    reset             = r.rst;
    bus.ID_rd         = r.rd;
    bus.ID_RF_Enable  = r.we;
    bus.ID_Load_Instr = r.ld;
    bus.ID_rs1        = r.rs1;
    bus.ID_uses_rs1   = r.u1;
    bus.ID_rs2        = r.rs2;
    bus.ID_uses_rs2   = r.u2;
    bus.EX_flush      = r.fl;
  endtask

  task automatic clear_pipe();
    drive(mk(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_RST, 2'b00, 2'b00));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t e;
    rows.push_back(mk(1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, C_RST,  2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, C_NORM, 2'b00, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL reset[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.stall_count !== 32'd0 || bus.fwd_count !== 32'd0) begin
          n_bad++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.stall_count, bus.fwd_count);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, C_STALL, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, C_NORM,  2'b10, 2'b00));
    rows.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  2'b00, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL load_use[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.stall_count !== (STATS ? 32'd1 : 32'd0)) begin
      n_bad++; $display("FAIL load_use_stall_count: got %0d expected %0d", bus.stall_count, STATS ? 1 : 0);
    end
    n_cmp++;
    if (bus.fwd_count !== (STATS ? 32'd1 : 32'd0)) begin
      n_bad++; $display("FAIL load_use_fwd_count: got %0d expected %0d", bus.fwd_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd3, 1'b1, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, C_NORM, 2'b01, 2'b01));
    rows.push_back(mk(1'b0, 5'd5, 1'b1, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, C_NORM, 2'b01, 2'b10));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, C_NORM, 2'b11, 2'b10));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.fwd_count !== (STATS ? 32'd6 : 32'd0) || bus.stall_count !== 32'd0) begin
      n_bad++; $display("FAIL back_to_back_counters: got %0d/%0d expected 0/%0d",
                        bus.stall_count, bus.fwd_count, STATS ? 6 : 0);
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_NORM, 2'b01, 2'b00));
    rows.push_back(mk(1'b0, 5'd1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_NORM, 2'b10, 2'b00));
    rows.push_back(mk(1'b0, 5'd1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_NORM, 2'b11, 2'b00));
    rows.push_back(mk(1'b0, 5'd1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL priority[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.fwd_count !== (STATS ? 32'd3 : 32'd0)) begin
      n_bad++; $display("FAIL priority_fwd_count: got %0d expected %0d", bus.fwd_count, STATS ? 3 : 0);
    end
  endtask

  task automatic test_x0();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, C_NORM, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, C_NORM, 2'b00, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL x0[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b1, C_FLUSH, 2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd8, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b1, C_FLUSH, 2'b11, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL flush[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.stall_count !== 32'd0 || bus.fwd_count !== 32'd0) begin
      n_bad++; $display("FAIL flush_counters: got %0d/%0d expected 0/0", bus.stall_count, bus.fwd_count);
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[$];
    row_t e;
    clear_pipe();
    rows.push_back(mk(1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_NORM,  2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, C_STALL, 2'b00, 2'b00));
    rows.push_back(mk(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, C_RST,   2'b00, 2'b00));
    rows.push_back(mk(1'b0, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, C_NORM,  2'b00, 2'b00));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (outs() !== e.exp) begin
        n_bad++; $display("FAIL reset_mid_stall[%0d]: got %b expected %b", i, outs(), e.exp);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.stall_count !== 32'd0 || bus.fwd_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid_stall_counters: got %0d/%0d expected 0/0",
                        bus.stall_count, bus.fwd_count);
    end
  endtask

  initial begin
    drive(mk(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, C_RST, 2'b00, 2'b00));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_priority();
    test_x0();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
